frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/vga_pkg.sv | 22 ++
 rtl/xy_counter.sv | 44 ++++
 rtl/frame_scheduler.sv | 121 ++++++++++++
 tb/tb_frame_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA frame constants, FSM encoding and a saturating counter helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned RGB_W        = 16;
  localparam int unsigned X_W          = 12;
  localparam int unsigned Y_W          = 11;
  localparam int unsigned UND_W        = 16;

  localparam logic [RGB_W-1:0] FILL_RGB_DEF = 16'h001F;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic [UND_W-1:0] sat_inc(input logic [UND_W-1:0] v);
    return (v == {UND_W{1'b1}}) ? v : v + UND_W'(1);
  endfunction

endpackage

// File: rtl/xy_counter.sv
// Raster position counter: x wraps at H_ACTIVE-1 and carries into y.
module xy_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == X_W'(H_ACTIVE - 1));
  assign w_y_end = (r_y == Y_W'(V_ACTIVE - 1));

  // clear wins over advance so a retrigger on the final slot restarts at the origin
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = w_x_end && w_y_end;

endmodule

// File: rtl/frame_scheduler.sv
// Streams one frame of pixels from the selected requester into the VGA FIFO,
// inserting fill pixels when the source runs dry.
module frame_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned      H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned      V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [RGB_W-1:0] FILL_RGB = FILL_RGB_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vtrigger,
  input  logic             src_sel,
  input  logic [RGB_W-1:0] src0_data,
  input  logic             src0_valid,
  output logic             src0_ready,
  input  logic [RGB_W-1:0] src1_data,
  input  logic             src1_valid,
  output logic             src1_ready,
  input  logic             fifo_full,
  output logic             fifo_write,
  output logic [RGB_W-1:0] fifo_data,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             busy,
  output logic             frame_done,
  output logic             vtrigger_late,
  output logic [UND_W-1:0] underrun_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel;
  logic             r_fifo_write;
  logic [RGB_W-1:0] r_fifo_data;
  logic             r_frame_done;
  logic             r_late;
  logic [UND_W-1:0] r_underrun;

  logic             w_slot;
  logic             w_accept;
  logic             w_last;
  logic             w_end_slot;
  logic             w_src_valid;
  logic [RGB_W-1:0] w_pix;

  xy_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_xy (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept),
    .advance (w_slot),
    .x       (pix_x),
    .y       (pix_y),
    .last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A trigger on the final slot chains straight into the next frame
  always_comb begin
    w_state_nxt = r_state;
    w_slot      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (vtrigger) begin
          w_state_nxt = ST_ACTIVE;
          w_accept    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_slot = !fifo_full;
        if (w_slot && w_last) begin
          if (vtrigger) w_accept    = 1'b1;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_end_slot  = w_slot && w_last;
  assign w_src_valid = r_sel ? src1_valid : src0_valid;
  assign w_pix       = !w_src_valid ? FILL_RGB : (r_sel ? src1_data : src0_data);

  assign src0_ready  = w_slot && !r_sel && src0_valid;
  assign src1_ready  = w_slot &&  r_sel && src1_valid;
  assign busy        = (r_state == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= 1'b0;
      r_fifo_write <= 1'b0;
      r_fifo_data  <= '0;
      r_frame_done <= 1'b0;
      r_late       <= 1'b0;
      r_underrun   <= '0;
    end else begin
      if (w_accept) r_sel <= src_sel;
      r_fifo_write <= w_slot;
      if (w_slot) r_fifo_data <= w_pix;
      r_frame_done <= w_end_slot;
      r_late       <= vtrigger && (r_state == ST_ACTIVE) && !w_end_slot;
      if (w_accept)                    r_underrun <= '0;
      else if (w_slot && !w_src_valid) r_underrun <= sat_inc(r_underrun);
    end
  end

  assign fifo_write    = r_fifo_write;
  assign fifo_data     = r_fifo_data;
  assign frame_done    = r_frame_done;
  assign vtrigger_late = r_late;
  assign underrun_cnt  = r_underrun;

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized bench for frame_scheduler on an 8x4 frame, compared against a
// pixel-index reference model.
module tb_frame_scheduler;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 4;
  localparam int unsigned NPIX = H * V;
  localparam logic [15:0] FILL = 16'h001F;

  logic        clk = 1'b0;
  logic        reset, vtrigger, src_sel;
  logic [15:0] src0_data, src1_data;
  logic        src0_valid, src1_valid, src0_ready, src1_ready;
  logic        fifo_full, fifo_write;
  logic [15:0] fifo_data;
  logic [11:0] pix_x;
  logic [10:0] pix_y;
  logic        busy, frame_done, vtrigger_late;
  logic [15:0] underrun_cnt;

  frame_scheduler #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .FILL_RGB (FILL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vtrigger      (vtrigger),
    .src_sel       (src_sel),
    .src0_data     (src0_data),
    .src0_valid    (src0_valid),
    .src0_ready    (src0_ready),
    .src1_data     (src1_data),
    .src1_valid    (src1_valid),
    .src1_ready    (src1_ready),
    .fifo_full     (fifo_full),
    .fifo_write    (fifo_write),
    .fifo_data     (fifo_data),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .busy          (busy),
    .frame_done    (frame_done),
    .vtrigger_late (vtrigger_late),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame progress as a linear pixel index.
  bit          m_valid  = 0;
  bit          m_active = 0;
  bit          m_sel    = 0;
  int          m_n      = 0;
  int          m_under  = 0;
  bit          e_write  = 0;
  bit          e_done   = 0;
  bit          e_late   = 0;
  logic [15:0] e_data   = '0;
  int          obs_writes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rnd_data();
    src0_data = 16'($urandom);
    src1_data = 16'($urandom);
  endtask

  // Inputs are already driven; check readies, advance the model, then check outputs.
  task automatic tick();
    bit          slot, was_active, fin, v;
    logic [15:0] d;
    #1;
    slot = m_active && !fifo_full;
    if (m_valid) begin
      chk("src0_ready", src0_ready, slot && !m_sel && src0_valid);
      chk("src1_ready", src1_ready, slot &&  m_sel && src1_valid);
    end
    if (reset) begin
      m_valid = 1; m_active = 0; m_sel = 0; m_n = 0; m_under = 0;
      e_write = 0; e_done = 0; e_late = 0; e_data = '0;
    end else begin
      was_active = m_active;
      fin        = 0;
      e_write    = slot;
      e_done     = 0;
      e_late     = 0;
      if (slot) begin
        v = m_sel ? src1_valid : src0_valid;
        d = m_sel ? src1_data  : src0_data;
        e_data = v ? d : FILL;
        if (!v && m_under < 65535) m_under++;
        m_n++;
        if (m_n == NPIX) begin
          fin = 1; e_done = 1; m_active = 0; m_n = 0;
        end
      end
      if (vtrigger) begin
        if (!was_active || fin) begin
          m_active = 1; m_n = 0; m_under = 0; m_sel = src_sel;
        end else begin
          e_late = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (m_valid) begin
      chk("fifo_write",    fifo_write,    e_write);
      chk("fifo_data",     fifo_data,     e_data);
      chk("frame_done",    frame_done,    e_done);
      chk("vtrigger_late", vtrigger_late, e_late);
      chk("busy",          busy,          m_active);
      chk("pix_x",         pix_x,         32'(m_n % H));
      chk("pix_y",         pix_y,         32'(m_n / H));
      chk("underrun_cnt",  underrun_cnt,  32'(m_under));
      if (fifo_write) obs_writes++;
      if (frame_done) begin
        chk("frame_writes", 32'(obs_writes), NPIX);
        obs_writes = 0;
      end
    end
    if (reset) obs_writes = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_data();
      tick();
    end
  endtask

  task automatic start_frame(input bit sel);
    src_sel  = sel;
    vtrigger = 1'b1;
    rnd_data();
    tick();
    vtrigger = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vtrigger = 1'b0; src_sel = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0; fifo_full = 1'b0;
    src0_data = '0; src1_data = '0;
    @(negedge clk);
    run(2);
    reset = 1'b0;
    run(2);

    // Continuous source 0, no back-pressure
    src0_valid = 1'b1;
    start_frame(1'b0);
    run(36);

    // Source 0 alternating valid/invalid each slot; source 1 noise must be ignored
    start_frame(1'b0);
    for (int i = 0; i < 36; i++) begin
      src0_valid = (i % 2 == 0);
      src1_valid = 1'($urandom);
      rnd_data();
      tick();
    end

    // Back-pressure for 5 cycles at slot 10
    src0_valid = 1'b1;
    start_frame(1'b0);
    run(10);
    fifo_full = 1'b1;
    run(5);
    fifo_full = 1'b0;
    run(30);

    // Late trigger at slot 5, chained trigger on the last slot, src_sel noise mid-frame
    src1_valid = 1'b1;
    start_frame(1'b1);
    run(5);
    vtrigger = 1'b1; rnd_data(); tick(); vtrigger = 1'b0;
    for (int i = 0; i < 25; i++) begin
      src_sel = 1'($urandom);
      rnd_data();
      tick();
    end
    src_sel = 1'b0;
    vtrigger = 1'b1; rnd_data(); tick(); vtrigger = 1'b0;
    run(40);

    // Reset at slot 17, then a clean frame
    start_frame(1'b0);
    run(17);
    reset = 1'b1; rnd_data(); tick(); reset = 1'b0;
    run(3);
    start_frame(1'b0);
    run(40);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      reset      = ($urandom_range(0, 399) == 0);
      vtrigger   = ($urandom_range(0, 29) == 0);
      src_sel    = 1'($urandom);
      src0_valid = ($urandom_range(0, 9) < 7);
      src1_valid = ($urandom_range(0, 9) < 7);
      fifo_full  = ($urandom_range(0, 3) == 0);
      rnd_data();
      tick();
    end
    reset = 1'b0; vtrigger = 1'b0; fifo_full = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
